cpu_reg_bank_dual_read: RTL and testbench

Programmer-visible register bank for the 6502 core: A, X, Y and S behind a single write port and two independent read ports. It is the read-side counterpart of the two-input load registers. Those registers merge two sources into one stored value; this block fans one stored set out to two consumers in the same cycle, the SB-side and DB-side internal buses, e.g. ALU A input and B-register input. S carries a built-in wrapping inc/dec counter for push/pull sequencing.

---
 rtl/cpu_regbank_pkg.sv | 19 +
 rtl/cpu_reg_bank_dual_read_if.sv | 49 ++++
 rtl/cpu_reg_bank_dual_read_sp_counter.sv | 58 +++++
 rtl/cpu_reg_bank_dual_read.sv | 126 ++++++++++++
 tb/tb_cpu_reg_bank_dual_read.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_regbank_pkg.sv
// Shared types and constants for the 6502 programmer-visible register bank.
// Holds the register select encoding and the reset values of A/X/Y and S.
package cpu_regbank_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    // Register select used by the write port and both read ports
    typedef enum logic [SEL_W-1:0] {
        REG_A = 2'd0,
        REG_X = 2'd1,
        REG_Y = 2'd2,
        REG_S = 2'd3
    } reg_sel_t;

    localparam logic [DATA_W-1:0] GP_RESET_VAL     = 8'h00;
    localparam logic [DATA_W-1:0] SP_RESET_DEFAULT = 8'hFD;

endpackage

// File: rtl/cpu_reg_bank_dual_read_if.sv
// Bus bundle for cpu_reg_bank_dual_read.
// Carries the single write port, the two read ports (rd0 = SB side,
// rd1 = DB side) and the stack pointer inc/dec controls plus sp_wrap.
// master: the core sequencer driving requests; slave: the register bank.
interface cpu_reg_bank_dual_read_if
    import cpu_regbank_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) ();

    logic             wr_en;
    reg_sel_t         wr_sel;
    logic [WIDTH-1:0] wr_data;

    logic             rd0_en;
    reg_sel_t         rd0_sel;
    logic [WIDTH-1:0] rd0_data;
    logic             rd0_valid;

    logic             rd1_en;
    reg_sel_t         rd1_sel;
    logic [WIDTH-1:0] rd1_data;
    logic             rd1_valid;

    logic             sp_inc;
    logic             sp_dec;
    logic             sp_wrap;

    modport master (
        output wr_en, wr_sel, wr_data,
        output rd0_en, rd0_sel,
        output rd1_en, rd1_sel,
        output sp_inc, sp_dec,
        input  rd0_data, rd0_valid,
        input  rd1_data, rd1_valid,
        input  sp_wrap
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        input  rd0_en, rd0_sel,
        input  rd1_en, rd1_sel,
        input  sp_inc, sp_dec,
        output rd0_data, rd0_valid,
        output rd1_data, rd1_valid,
        output sp_wrap
    );

endinterface

// File: rtl/cpu_reg_bank_dual_read_sp_counter.sv
// Stack pointer register S with a wrapping inc/dec counter.
// Ports:
//   clk, rst_n  : core clock, async active-low reset
//   wr_en       : direct write of S (highest priority)
//   wr_data     : value written when wr_en
//   inc, dec    : S+1 / S-1; both together leave S unchanged
//   sp          : current S
//   sp_next_c   : combinational value S takes on the next edge
//   sp_wrap     : registered pulse, S wrapped FF->00 or 00->FF on the last edge
module sp_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] SP_RESET = 8'hFD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] sp_next_c,
    output logic             sp_wrap
);

    logic [WIDTH-1:0] sp_q;
    logic             wrap_q;
    logic             wrap_next_c;

    // Write beats counting; inc+dec cancel; wrap detected from the old value
    always_comb begin
        sp_next_c   = sp_q;
        wrap_next_c = 1'b0;
        if (wr_en) begin
            sp_next_c = wr_data;
        end else if (inc && !dec) begin
            sp_next_c   = sp_q + WIDTH'(1);
            wrap_next_c = &sp_q;
        end else if (dec && !inc) begin
            sp_next_c   = sp_q - WIDTH'(1);
            wrap_next_c = ~|sp_q;
        end
    end

    // S and wrap pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q   <= SP_RESET;
            wrap_q <= 1'b0;
        end else begin
            sp_q   <= sp_next_c;
            wrap_q <= wrap_next_c;
        end
    end

    assign sp      = sp_q;
    assign sp_wrap = wrap_q;

endmodule

// File: rtl/cpu_reg_bank_dual_read.sv
// 6502 register bank: A, X, Y, S behind one write port and two independent
// registered read ports (rd0 feeds the SB bus, rd1 feeds the DB bus).
// Ports:
//   clk, rst_n : core clock, async active-low reset
//   bus        : cpu_reg_bank_dual_read_if.slave (write, rd0, rd1, sp_inc/dec, sp_wrap)
// Build option: define REGBANK_BYPASS_EN to have a read that coincides with
// an update of the same register return the post-update value; otherwise
// the read returns the value held before the edge.
module cpu_reg_bank_dual_read
    import cpu_regbank_pkg::*;
#(
    parameter int unsigned      WIDTH    = DATA_W,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_DEFAULT)
) (
    input logic                      clk,
    input logic                      rst_n,
    cpu_reg_bank_dual_read_if.slave  bus
);

    logic [WIDTH-1:0] a_q, x_q, y_q;
    logic [WIDTH-1:0] a_next_c, x_next_c, y_next_c;
    logic [WIDTH-1:0] sp_cur, sp_next_c;
    logic             sp_wrap;
    logic             sp_wr_c;

    logic [WIDTH-1:0] rd0_q, rd1_q;
    logic             rd0_valid_q, rd1_valid_q;
    logic [WIDTH-1:0] rd0_src_c, rd1_src_c;

    function automatic logic [WIDTH-1:0] pick(
        input reg_sel_t         sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] s
    );
        logic [WIDTH-1:0] v;
        v = a;
        case (sel)
            REG_A: v = a;
            REG_X: v = x;
            REG_Y: v = y;
            REG_S: v = s;
        endcase
        return v;
    endfunction

    assign sp_wr_c = bus.wr_en && (bus.wr_sel == REG_S);

    // Next values of the general-purpose registers
    always_comb begin
        a_next_c = a_q;
        x_next_c = x_q;
        y_next_c = y_q;
        if (bus.wr_en) begin
            case (bus.wr_sel)
                REG_A: a_next_c = bus.wr_data;
                REG_X: x_next_c = bus.wr_data;
                REG_Y: y_next_c = bus.wr_data;
                REG_S: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= WIDTH'(GP_RESET_VAL);
            x_q <= WIDTH'(GP_RESET_VAL);
            y_q <= WIDTH'(GP_RESET_VAL);
        end else begin
            a_q <= a_next_c;
            x_q <= x_next_c;
            y_q <= y_next_c;
        end
    end

    sp_counter #(
        .WIDTH    (WIDTH),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (sp_wr_c),
        .wr_data   (bus.wr_data),
        .inc       (bus.sp_inc),
        .dec       (bus.sp_dec),
        .sp        (sp_cur),
        .sp_next_c (sp_next_c),
        .sp_wrap   (sp_wrap)
    );

    // Read muxes: next-state view forwards same-edge updates, current view does not
`ifdef REGBANK_BYPASS_EN
    assign rd0_src_c = pick(bus.rd0_sel, a_next_c, x_next_c, y_next_c, sp_next_c);
    assign rd1_src_c = pick(bus.rd1_sel, a_next_c, x_next_c, y_next_c, sp_next_c);
`else
    assign rd0_src_c = pick(bus.rd0_sel, a_q, x_q, y_q, sp_cur);
    assign rd1_src_c = pick(bus.rd1_sel, a_q, x_q, y_q, sp_cur);
`endif

    // Read output registers; data holds while the port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q       <= '0;
            rd1_q       <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            rd0_valid_q <= bus.rd0_en;
            rd1_valid_q <= bus.rd1_en;
            if (bus.rd0_en) begin
                rd0_q <= rd0_src_c;
            end
            if (bus.rd1_en) begin
                rd1_q <= rd1_src_c;
            end
        end
    end

    assign bus.rd0_data  = rd0_q;
    assign bus.rd0_valid = rd0_valid_q;
    assign bus.rd1_data  = rd1_q;
    assign bus.rd1_valid = rd1_valid_q;
    assign bus.sp_wrap   = sp_wrap;

endmodule

// File: tb/tb_cpu_reg_bank_dual_read.sv
// Self-checking bench for cpu_reg_bank_dual_read: directed vectors with
// literal expectations plus a per-cycle comparison against an array model.
module tb_cpu_reg_bank_dual_read;
    import cpu_regbank_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    cpu_reg_bank_dual_read_if #(.WIDTH(8)) bus ();

    cpu_reg_bank_dual_read #(.WIDTH(8), .SP_RESET(8'hFD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_reg [4];
    logic [7:0] m_rd0, m_rd1;
    logic       m_v0, m_v1, m_wrap;

    // Value register s holds after the coming edge
    function automatic logic [7:0] post_val(input int s);
        if (bus.wr_en && int'(bus.wr_sel) == s) return bus.wr_data;
        if (s == 3 && bus.sp_inc && !bus.sp_dec) return m_reg[3] + 8'd1;
        if (s == 3 && bus.sp_dec && !bus.sp_inc) return m_reg[3] - 8'd1;
        return m_reg[s];
    endfunction

    function automatic logic [7:0] read_val(input int s);
`ifdef REGBANK_BYPASS_EN
        return post_val(s);
`else
        return m_reg[s];
`endif
    endfunction

    function automatic logic wrap_val();
        int s;
        s = int'(m_reg[3]);
        if (bus.wr_en && bus.wr_sel == REG_S) return 1'b0;
        if (bus.sp_inc && !bus.sp_dec) return (s + 1) > 255;
        if (bus.sp_dec && !bus.sp_inc) return (s - 1) < 0;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg[0] <= 8'h00;
            m_reg[1] <= 8'h00;
            m_reg[2] <= 8'h00;
            m_reg[3] <= 8'hFD;
            m_rd0    <= 8'h00;
            m_rd1    <= 8'h00;
            m_v0     <= 1'b0;
            m_v1     <= 1'b0;
            m_wrap   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) m_reg[i] <= post_val(i);
            m_wrap <= wrap_val();
            m_v0   <= bus.rd0_en;
            m_v1   <= bus.rd1_en;
            if (bus.rd0_en) m_rd0 <= read_val(int'(bus.rd0_sel));
            if (bus.rd1_en) m_rd1 <= read_val(int'(bus.rd1_sel));
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc rd0_data",  bus.rd0_data, m_rd0);
        check("cyc rd0_valid", 8'(bus.rd0_valid), 8'(m_v0));
        check("cyc rd1_data",  bus.rd1_data, m_rd1);
        check("cyc rd1_valid", 8'(bus.rd1_valid), 8'(m_v1));
        check("cyc sp_wrap",   8'(bus.sp_wrap), 8'(m_wrap));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wr_en  = 1'b0;
        bus.rd0_en = 1'b0;
        bus.rd1_en = 1'b0;
        bus.sp_inc = 1'b0;
        bus.sp_dec = 1'b0;
    endtask

    task automatic wr(input reg_sel_t sel, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.wr_sel  = REG_A;
        bus.wr_data = 8'h00;
        bus.rd0_sel = REG_A;
        bus.rd1_sel = REG_A;
        idle();
        #23 rst_n = 1'b1;

        // Reset value of S through port 0
        bus.rd0_en = 1'b1; bus.rd0_sel = REG_S;
        step();
        check("reset S rd0_data", bus.rd0_data, 8'hFD);
        check("reset S rd0_valid", 8'(bus.rd0_valid), 8'h01);
        idle();

        // Dual read
        wr(REG_A, 8'h3C); step();
        wr(REG_X, 8'hA5); step();
        idle();
        bus.rd0_en = 1'b1; bus.rd0_sel = REG_A;
        bus.rd1_en = 1'b1; bus.rd1_sel = REG_X;
        step();
        check("dual rd0_data", bus.rd0_data, 8'h3C);
        check("dual rd1_data", bus.rd1_data, 8'hA5);
        check("dual rd0_valid", 8'(bus.rd0_valid), 8'h01);
        check("dual rd1_valid", 8'(bus.rd1_valid), 8'h01);
        idle(); step();
        check("hold rd0_data", bus.rd0_data, 8'h3C);
        check("hold rd1_data", bus.rd1_data, 8'hA5);
        check("hold rd0_valid", 8'(bus.rd0_valid), 8'h00);

        // Wrap down then up
        wr(REG_S, 8'h00); step();
        idle(); bus.sp_dec = 1'b1; step();
        check("wrap dec sp_wrap", 8'(bus.sp_wrap), 8'h01);
        idle(); bus.rd0_en = 1'b1; bus.rd0_sel = REG_S; step();
        check("wrap dec pulse end", 8'(bus.sp_wrap), 8'h00);
        check("wrap dec S", bus.rd0_data, 8'hFF);
        idle(); bus.sp_inc = 1'b1; step();
        check("wrap inc sp_wrap", 8'(bus.sp_wrap), 8'h01);
        idle(); bus.rd0_en = 1'b1; bus.rd0_sel = REG_S; step();
        check("wrap inc S", bus.rd0_data, 8'h00);
        check("wrap inc pulse end", 8'(bus.sp_wrap), 8'h00);

        // Priority: write beats inc; inc+dec cancel
        idle(); wr(REG_S, 8'h40); bus.sp_inc = 1'b1; step();
        check("prio wr sp_wrap", 8'(bus.sp_wrap), 8'h00);
        idle(); bus.sp_inc = 1'b1; bus.sp_dec = 1'b1; step();
        check("prio incdec sp_wrap", 8'(bus.sp_wrap), 8'h00);
        idle(); bus.rd0_en = 1'b1; bus.rd0_sel = REG_S; step();
        check("prio S", bus.rd0_data, 8'h40);

        // Hazard on X via port 1
        idle(); wr(REG_X, 8'h11); step();
        wr(REG_X, 8'h22); bus.rd1_en = 1'b1; bus.rd1_sel = REG_X; step();
`ifdef REGBANK_BYPASS_EN
        check("hazard X rd1", bus.rd1_data, 8'h22);
`else
        check("hazard X rd1", bus.rd1_data, 8'h11);
`endif
        idle(); bus.rd1_en = 1'b1; bus.rd1_sel = REG_X; step();
        check("after hazard X rd1", bus.rd1_data, 8'h22);

        // Hazard on S dec via port 0
        idle(); wr(REG_S, 8'h80); step();
        idle(); bus.sp_dec = 1'b1; bus.rd0_en = 1'b1; bus.rd0_sel = REG_S; step();
`ifdef REGBANK_BYPASS_EN
        check("hazard S rd0", bus.rd0_data, 8'h7F);
`else
        check("hazard S rd0", bus.rd0_data, 8'h80);
`endif
        idle(); bus.rd0_en = 1'b1; bus.rd0_sel = REG_S; step();
        check("after hazard S rd0", bus.rd0_data, 8'h7F);

        // Both ports on the same register
        idle(); wr(REG_Y, 8'h5A); step();
        idle();
        bus.rd0_en = 1'b1; bus.rd0_sel = REG_Y;
        bus.rd1_en = 1'b1; bus.rd1_sel = REG_Y;
        step();
        check("same reg rd0", bus.rd0_data, 8'h5A);
        check("same reg rd1", bus.rd1_data, 8'h5A);

        // Mid-cycle asynchronous reset
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("async rst rd0_data", bus.rd0_data, 8'h00);
        check("async rst rd1_data", bus.rd1_data, 8'h00);
        check("async rst rd0_valid", 8'(bus.rd0_valid), 8'h00);
        check("async rst rd1_valid", 8'(bus.rd1_valid), 8'h00);
        check("async rst sp_wrap", 8'(bus.sp_wrap), 8'h00);
        #3 rst_n = 1'b1;
        bus.rd1_en = 1'b1; bus.rd1_sel = REG_S;
        bus.rd0_en = 1'b1; bus.rd0_sel = REG_Y;
        step();
        check("post rst S rd1", bus.rd1_data, 8'hFD);
        check("post rst Y rd0", bus.rd0_data, 8'h00);
        check("post rst rd1_valid", 8'(bus.rd1_valid), 8'h01);

        // Back-to-back mixed traffic, checked by the per-cycle model compare
        for (int i = 0; i < 40; i++) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_sel  = reg_sel_t'($urandom_range(0, 3));
            bus.wr_data = 8'($urandom_range(0, 255));
            bus.rd0_en  = 1'($urandom_range(0, 1));
            bus.rd0_sel = reg_sel_t'($urandom_range(0, 3));
            bus.rd1_en  = 1'($urandom_range(0, 1));
            bus.rd1_sel = reg_sel_t'($urandom_range(0, 3));
            bus.sp_inc  = 1'($urandom_range(0, 1));
            bus.sp_dec  = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
